// File: rtl/armsim_ctrl_pkg.sv
// Shared ARMSIM control-unit definitions: state width, ns_sel codes and named microstates.
package armsim_ctrl_pkg;

    localparam int unsigned STATE_W  = 7;
    localparam int unsigned NS_SEL_W = 3;

    typedef logic [STATE_W-1:0]  state_t;
    typedef logic [NS_SEL_W-1:0] ns_sel_t;

    localparam ns_sel_t NS_INC    = 3'd0;
    localparam ns_sel_t NS_JUMP   = 3'd1;
    localparam ns_sel_t NS_ENCODE = 3'd2;
    localparam ns_sel_t NS_CJUMP  = 3'd3;
    localparam ns_sel_t NS_WAIT   = 3'd4;
    localparam ns_sel_t NS_CALL   = 3'd5;
    localparam ns_sel_t NS_RET    = 3'd6;
    localparam ns_sel_t NS_FETCH  = 3'd7;

    localparam state_t RESET_STATE = 7'd0;
    localparam state_t FETCH_STATE = 7'd1;
    localparam state_t ERR_STATE   = 7'd91;

    // Successor state; wraps 127 -> 0 by design.
    function automatic state_t incState(input state_t s);
        return s + STATE_W'(1);
    endfunction

endpackage

// File: rtl/useq_wait_timer.sv
// Memory-wait watchdog for micro_sequencer: counts stalled WAIT cycles and raises a sticky timeout.
module useq_wait_timer #(
    parameter int unsigned MFA_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic waitStall,
    output logic timeoutHit_c,
    output logic mfaTimeout
);

    localparam int unsigned CNT_W = $clog2(MFA_TIMEOUT + 1);

    logic [CNT_W-1:0] waitCount;

    assign timeoutHit_c = waitStall && (waitCount == CNT_W'(MFA_TIMEOUT));

    // Counter restarts whenever the stall is broken or the timeout fires.
    always_ff @(posedge clk) begin
        if (reset) begin
            waitCount <= '0;
        end else if (!waitStall || timeoutHit_c) begin
            waitCount <= '0;
        end else begin
            waitCount <= waitCount + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mfaTimeout <= 1'b0;
        end else if (timeoutHit_c) begin
            mfaTimeout <= 1'b1;
        end
    end

endmodule

// File: rtl/micro_sequencer.sv
// ARMSIM microprogram sequencer: selects and registers the next microstore address each cycle.
// Optional memory-wait timeout is enabled by defining USEQ_MFA_TIMEOUT_EN.
module micro_sequencer
    import armsim_ctrl_pkg::*;
`ifdef USEQ_MFA_TIMEOUT_EN
#(
    parameter int unsigned MFA_TIMEOUT = 16
)
`endif
(
    input  logic                clk,
    input  logic                reset,
    input  logic [STATE_W-1:0]  enc_state,
    input  logic [NS_SEL_W-1:0] ns_sel,
    input  logic [STATE_W-1:0]  cr_addr,
    input  logic                cond_true,
    input  logic                mfa,
    output logic [STATE_W-1:0]  state_out,
    output logic [STATE_W-1:0]  ret_addr,
    output logic                mfa_timeout
);

    state_t stateReg;
    state_t stateNext;
    state_t retReg;
    state_t retNext;
    logic   waitStall;
    logic   timeoutHit_c;

    assign waitStall = (ns_sel == NS_WAIT) && !mfa;

`ifdef USEQ_MFA_TIMEOUT_EN
    useq_wait_timer #(
        .MFA_TIMEOUT (MFA_TIMEOUT)
    ) uWaitTimer (
        .clk          (clk),
        .reset        (reset),
        .waitStall    (waitStall),
        .timeoutHit_c (timeoutHit_c),
        .mfaTimeout   (mfa_timeout)
    );
`else
    assign timeoutHit_c = 1'b0;
    assign mfa_timeout  = 1'b0;
`endif

    // Control-state and return registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg <= RESET_STATE;
            retReg   <= '0;
        end else begin
            stateReg <= stateNext;
            retReg   <= retNext;
        end
    end

    // Next-state select; a timeout overrides the WAIT hold.
    always_comb begin
        stateNext = stateReg;
        if (timeoutHit_c) begin
            stateNext = ERR_STATE;
        end else begin
            case (ns_sel)
                NS_INC:    stateNext = incState(stateReg);
                NS_JUMP:   stateNext = cr_addr;
                NS_ENCODE: stateNext = cond_true ? enc_state : FETCH_STATE;
                NS_CJUMP:  stateNext = cond_true ? cr_addr : incState(stateReg);
                NS_WAIT:   stateNext = mfa ? incState(stateReg) : stateReg;
                NS_CALL:   stateNext = cr_addr;
                NS_RET:    stateNext = retReg;
                NS_FETCH:  stateNext = FETCH_STATE;
                default:   stateNext = stateReg;
            endcase
        end
    end

    // Return register loads only on CALL.
    always_comb begin
        retNext = retReg;
        if (ns_sel == NS_CALL) begin
            retNext = incState(stateReg);
        end
    end

    assign state_out = stateReg;
    assign ret_addr  = retReg;

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: directed vector table, hand sequences, random vs. model.
// Build with USEQ_MFA_TIMEOUT_EN defined to exercise the timeout path (MFA_TIMEOUT=4).
module tb_micro_sequencer;

`ifdef USEQ_MFA_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
    localparam int TO_LIM = 4;
`else
    localparam bit TO_EN = 1'b0;
    localparam int TO_LIM = 0;
`endif

    typedef struct {
        logic       rst;
        logic [6:0] enc;
        logic [2:0] sel;
        logic [6:0] cr;
        logic       cond;
        logic       mf;
        int         expState;
        int         expRet;
    } vec_t;

    logic       clk;
    logic       reset;
    logic [6:0] enc_state;
    logic [2:0] ns_sel;
    logic [6:0] cr_addr;
    logic       cond_true;
    logic       mfa;
    logic [6:0] state_out;
    logic [6:0] ret_addr;
    logic       mfa_timeout;

    int checks = 0;
    int errors = 0;

`ifdef USEQ_MFA_TIMEOUT_EN
    micro_sequencer #(.MFA_TIMEOUT(4)) dut (
`else
    micro_sequencer dut (
`endif
        .clk         (clk),
        .reset       (reset),
        .enc_state   (enc_state),
        .ns_sel      (ns_sel),
        .cr_addr     (cr_addr),
        .cond_true   (cond_true),
        .mfa         (mfa),
        .state_out   (state_out),
        .ret_addr    (ret_addr),
        .mfa_timeout (mfa_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, then compare all outputs.
    task automatic step(input logic r, input logic [6:0] e, input logic [2:0] s,
                        input logic [6:0] c, input logic ct, input logic m,
                        input int eS, input int eR, input int eF, input string tag);
        reset = r; enc_state = e; ns_sel = s; cr_addr = c; cond_true = ct; mfa = m;
        @(posedge clk);
        #1;
        check({tag, " state_out"}, int'(state_out), eS);
        check({tag, " ret_addr"}, int'(ret_addr), eR);
        check({tag, " mfa_timeout"}, int'(mfa_timeout), eF);
    endtask

    vec_t vecs[29];

    // Reference model state (plain integers, modulo-128 arithmetic).
    int mState, mRet, mWait, mFlag;

    task automatic modelStep(input logic r, input logic [6:0] e, input int s,
                             input logic [6:0] c, input logic ct, input logic m);
        int nxt;
        if (r) begin
            mState = 0; mRet = 0; mWait = 0; mFlag = 0;
            return;
        end
        if (TO_EN && s == 4 && !m && mWait == TO_LIM) begin
            mState = 91; mWait = 0; mFlag = 1;
            return;
        end
        mWait = (s == 4 && !m) ? mWait + 1 : 0;
        nxt = mState;
        if (s == 0) nxt = (mState + 1) % 128;
        else if (s == 1) nxt = int'(c);
        else if (s == 2) nxt = ct ? int'(e) : 1;
        else if (s == 3) nxt = ct ? int'(c) : (mState + 1) % 128;
        else if (s == 4) nxt = m ? (mState + 1) % 128 : mState;
        else if (s == 5) begin nxt = int'(c); mRet = (mState + 1) % 128; end
        else if (s == 6) nxt = mRet;
        else nxt = 1;
        mState = nxt;
    endtask

    initial begin
        reset = 1'b1; enc_state = '0; ns_sel = '0; cr_addr = '0; cond_true = 1'b0; mfa = 1'b0;

        //        rst  enc    sel   cr     cond mfa  state ret
        vecs[0]  = '{1'b1, 7'd0,  3'd0, 7'd0,   1'b0, 1'b0, 0,   0};
        vecs[1]  = '{1'b1, 7'd0,  3'd0, 7'd0,   1'b0, 1'b0, 0,   0};
        vecs[2]  = '{1'b0, 7'd0,  3'd0, 7'd0,   1'b0, 1'b0, 1,   0};
        vecs[3]  = '{1'b0, 7'd0,  3'd0, 7'd0,   1'b0, 1'b0, 2,   0};
        vecs[4]  = '{1'b0, 7'd0,  3'd0, 7'd0,   1'b0, 1'b0, 3,   0};
        vecs[5]  = '{1'b0, 7'd43, 3'd2, 7'd0,   1'b1, 1'b0, 43,  0};
        vecs[6]  = '{1'b0, 7'd43, 3'd2, 7'd0,   1'b0, 1'b0, 1,   0};
        vecs[7]  = '{1'b0, 7'd0,  3'd1, 7'd5,   1'b0, 1'b0, 5,   0};
        vecs[8]  = '{1'b0, 7'd0,  3'd5, 7'd100, 1'b0, 1'b0, 100, 6};
        vecs[9]  = '{1'b0, 7'd0,  3'd0, 7'd0,   1'b0, 1'b0, 101, 6};
        vecs[10] = '{1'b0, 7'd0,  3'd6, 7'd0,   1'b0, 1'b0, 6,   6};
        vecs[11] = '{1'b0, 7'd0,  3'd1, 7'd20,  1'b0, 1'b0, 20,  6};
        vecs[12] = '{1'b0, 7'd0,  3'd4, 7'd0,   1'b0, 1'b0, 20,  6};
        vecs[13] = '{1'b0, 7'd0,  3'd4, 7'd0,   1'b0, 1'b0, 20,  6};
        vecs[14] = '{1'b0, 7'd0,  3'd4, 7'd0,   1'b0, 1'b0, 20,  6};
        vecs[15] = '{1'b0, 7'd0,  3'd4, 7'd0,   1'b0, 1'b0, 20,  6};
        vecs[16] = '{1'b0, 7'd0,  3'd4, 7'd0,   1'b0, 1'b1, 21,  6};
        vecs[17] = '{1'b0, 7'd0,  3'd3, 7'd50,  1'b1, 1'b0, 50,  6};
        vecs[18] = '{1'b0, 7'd0,  3'd3, 7'd50,  1'b0, 1'b0, 51,  6};
        vecs[19] = '{1'b0, 7'd0,  3'd7, 7'd0,   1'b0, 1'b0, 1,   6};
        vecs[20] = '{1'b0, 7'd0,  3'd1, 7'd127, 1'b0, 1'b0, 127, 6};
        vecs[21] = '{1'b0, 7'd0,  3'd0, 7'd0,   1'b0, 1'b0, 0,   6};
        vecs[22] = '{1'b0, 7'd0,  3'd5, 7'd127, 1'b0, 1'b0, 127, 1};
        vecs[23] = '{1'b0, 7'd0,  3'd5, 7'd10,  1'b0, 1'b0, 10,  0};
        vecs[24] = '{1'b0, 7'd0,  3'd6, 7'd0,   1'b0, 1'b0, 0,   0};
        vecs[25] = '{1'b0, 7'd0,  3'd1, 7'd20,  1'b0, 1'b0, 20,  0};
        vecs[26] = '{1'b0, 7'd0,  3'd4, 7'd0,   1'b0, 1'b0, 20,  0};
        vecs[27] = '{1'b1, 7'd0,  3'd4, 7'd0,   1'b0, 1'b0, 0,   0};
        vecs[28] = '{1'b0, 7'd0,  3'd2, 7'd0,   1'b1, 1'b0, 0,   0};

        for (int i = 0; i < 29; i++) begin
            step(vecs[i].rst, vecs[i].enc, vecs[i].sel, vecs[i].cr, vecs[i].cond, vecs[i].mf,
                 vecs[i].expState, vecs[i].expRet, 0, $sformatf("vec%0d", i));
        end

        // Timeout corner cases, or an unbounded stall when the watchdog is absent.
        step(1'b1, 7'd0, 3'd0, 7'd0, 1'b0, 1'b0, 0, 0, 0, "to_rst");
        step(1'b0, 7'd0, 3'd1, 7'd30, 1'b0, 1'b0, 30, 0, 0, "to_jmp");
        if (TO_EN) begin
            for (int i = 0; i < 4; i++)
                step(1'b0, 7'd0, 3'd4, 7'd0, 1'b0, 1'b0, 30, 0, 0, $sformatf("to_wait%0d", i));
            step(1'b0, 7'd0, 3'd4, 7'd0, 1'b0, 1'b0, 91, 0, 1, "to_hit");
            step(1'b0, 7'd0, 3'd0, 7'd0, 1'b0, 1'b0, 92, 0, 1, "to_sticky");
            step(1'b1, 7'd0, 3'd0, 7'd0, 1'b0, 1'b0, 0, 0, 0, "to_clear");
            step(1'b0, 7'd0, 3'd1, 7'd30, 1'b0, 1'b0, 30, 0, 0, "to_jmp2");
            for (int i = 0; i < 4; i++)
                step(1'b0, 7'd0, 3'd4, 7'd0, 1'b0, 1'b0, 30, 0, 0, $sformatf("to_wb%0d", i));
            step(1'b0, 7'd0, 3'd4, 7'd0, 1'b0, 1'b1, 31, 0, 0, "to_mfa_wins");
        end else begin
            for (int i = 0; i < 40; i++)
                step(1'b0, 7'd0, 3'd4, 7'd0, 1'b0, 1'b0, 30, 0, 0, $sformatf("long_wait%0d", i));
            step(1'b0, 7'd0, 3'd4, 7'd0, 1'b0, 1'b1, 31, 0, 0, "long_wait_done");
        end

        // Randomised run against the reference model.
        modelStep(1'b1, 7'd0, 0, 7'd0, 1'b0, 1'b0);
        step(1'b1, 7'd0, 3'd0, 7'd0, 1'b0, 1'b0, mState, mRet, mFlag, "rnd_rst");
        for (int i = 0; i < 3000; i++) begin
            logic       r, ct, m;
            logic [6:0] e, c;
            logic [2:0] s;
            r  = ($urandom_range(0, 99) == 0);
            e  = 7'($urandom);
            c  = 7'($urandom);
            s  = 3'($urandom);
            ct = 1'($urandom);
            m  = ($urandom_range(0, 3) == 0);
            // Bias toward WAIT runs so stalls and timeouts actually occur.
            if ($urandom_range(0, 2) == 0) s = 3'd4;
            modelStep(r, e, int'(s), c, ct, m);
            step(r, e, s, c, ct, m, mState, mRet, mFlag, $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
